bits_pack: RTL

//  Variable-length bit packer: the transmit-side counterpart of the variable-length bit unpacker.
//  - Accepts fields of 0..15 bits per cycle and packs them LSB-first into 32-bit words.
//  - Bit 0 of the first field lands in dataout[0] of the first word.
//  - Sits between the field encoders and the 32-bit word bus that feeds the unpacker.

---
 rtl/bits_pkg.sv | 19 +
 rtl/bits_outreg.sv | 41 ++++
 rtl/bits_pack.sv | 103 ++++++++++
 3 files changed

// File: rtl/bits_pkg.sv
// bits_pkg: shared widths, types and field masking for the bit packer
package bits_pkg;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 15;
    localparam int LEN_W   = 4;
    localparam int ACC_W   = 64;
    localparam int FILL_W  = 6;

    typedef logic [LEN_W-1:0]   len_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [FIELD_W-1:0] field_t;

    // Keeps the low len bits of a field; bits at index >= len are cleared.
    function automatic field_t field_mask(len_t len);
        return ~({FIELD_W{1'b1}} << len);
    endfunction

endpackage

// File: rtl/bits_outreg.sv
// bits_outreg: single-entry output holding register with valid/stall handshake
module bits_outreg
    import bits_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  word_t word_i,
    input  logic  stall_i,
    output logic  push_o,
    output word_t data_o,
    output logic  empty_o,
    output logic  draining_o
);

    logic  push_q, push_d;
    word_t data_q, data_d;

    // A loaded word stays valid until a cycle with no stall consumes it.
    always_comb begin
        push_d = load_i | (push_q & stall_i);
        data_d = load_i ? word_i : data_q;
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q <= 1'b0;
            data_q <= '0;
        end else begin
            push_q <= push_d;
            data_q <= data_d;
        end
    end

    assign push_o     = push_q;
    assign data_o     = data_q;
    assign empty_o    = ~push_q;
    assign draining_o = push_q & ~stall_i;

endmodule

// File: rtl/bits_pack.sv
// bits_pack: packs 0..15-bit fields LSB-first into 32-bit words.
// Optional partial-word flush is enabled with BITS_PACK_FLUSH_EN.
module bits_pack
    import bits_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pushin,
    input  logic [LEN_W-1:0]   lenin,
    input  logic [FIELD_W-1:0] datain,
`ifdef BITS_PACK_FLUSH_EN
    input  logic               flushin,
`endif
    output logic               stopout,
    input  logic               stallin,
    output logic               pushout,
    output logic [WORD_W-1:0]  dataout
);

    logic              push_q;
    len_t              len_q;
    field_t            data_q;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_m;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W:0]   fill_m;
    logic              merge, ext, load, out_empty, out_draining, can_load, flush_emit;

`ifdef BITS_PACK_FLUSH_EN
    logic flush_q, pend_q, pend_d, pend_clr;

    // A pending flush emits the zero-padded tail once no full word remains.
    always_comb begin
        flush_emit = pend_q && fill_q != '0 && fill_q < FILL_W'(WORD_W) && can_load;
        pend_clr   = pend_q && fill_q < FILL_W'(WORD_W) && (fill_q == '0 || can_load);
        pend_d     = flush_q | (pend_q & ~pend_clr);
    end

    // Flush request travels with its field, then waits as a pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            flush_q <= flushin;
            pend_q  <= pend_d;
        end
    end

    assign stopout = (fill_q > FILL_W'(33)) | flush_q | pend_q;
`else
    assign flush_emit = 1'b0;
    assign stopout    = fill_q > FILL_W'(33);
`endif

    // Input stage: every edge, with unused high field bits cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q <= 1'b0;
            len_q  <= '0;
            data_q <= '0;
        end else begin
            push_q <= pushin;
            len_q  <= lenin;
            data_q <= datain & field_mask(lenin);
        end
    end

    // Merge at the fill point and extract a word from the pre-merge low bits on the same edge.
    always_comb begin
        can_load = out_empty | out_draining;
        merge    = push_q && len_q != '0;
        acc_m    = merge ? (acc_q | (ACC_W'(data_q) << fill_q)) : acc_q;
        fill_m   = {1'b0, fill_q} + (merge ? (FILL_W+1)'(len_q) : '0);
        ext      = fill_q >= FILL_W'(WORD_W) && can_load;
        load     = ext | flush_emit;
        acc_d    = ext ? (acc_m >> WORD_W) : flush_emit ? '0 : acc_m;
        fill_d   = ext ? FILL_W'(fill_m - (FILL_W+1)'(WORD_W)) : flush_emit ? '0 : FILL_W'(fill_m);
    end

    // Accumulator and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    bits_outreg u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .word_i     (acc_q[WORD_W-1:0]),
        .stall_i    (stallin),
        .push_o     (pushout),
        .data_o     (dataout),
        .empty_o    (out_empty),
        .draining_o (out_draining)
    );

endmodule
